// File: rtl/text_term_ctrl_pkg.sv
// Shared constants, FSM state encoding and buffer address helper for the
// terminal write controller.
package term_pkg;

  localparam int unsigned COLS     = 70;
  localparam int unsigned ROWS     = 30;
  localparam int unsigned BUF_ROWS = 32;
  localparam logic [7:0]  BLANK_CH = 8'h20;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_NEWLINE,
    ST_SCROLL_CLR,
    ST_BACKSPACE,
    ST_CLR_ALL
  } state_t;

  function automatic logic [11:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
    return {prow, col};
  endfunction

endpackage

// File: rtl/text_term_ctrl_if.sv
// Char-buffer port shared between the terminal writer and the display reader.
interface text_term_ctrl_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              wr_slot;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_din;
  logic              buf_we;

  modport master (input wr_slot, disp_addr, output buf_addr, buf_din, buf_we);
  modport slave  (output wr_slot, disp_addr, input buf_addr, buf_din, buf_we);
endinterface

// File: rtl/text_term_ctrl_buf_port_mux.sv
// Holds one queued buffer write and issues it only during a display blanking slot;
// the display read address owns the port at all other times.
module buf_port_mux #(
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  output logic              done,
  text_term_ctrl_if.master  bus
);
  logic              wr_pending;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pending <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else if (req) begin
      wr_pending <= 1'b1;
      wr_addr    <= addr;
      wr_data    <= data;
    end else if (bus.buf_we) begin
      wr_pending <= 1'b0;
    end
  end

  assign bus.buf_we   = wr_pending & bus.wr_slot;
  assign bus.buf_addr = bus.buf_we ? wr_addr : bus.disp_addr;
  assign bus.buf_din  = wr_data;
  assign done         = bus.buf_we;

endmodule

// File: rtl/text_term_ctrl.sv
// Terminal write controller: cursor, per-line ends, scroll offset and the
// sequencing of every char-buffer write for the 70x30 display.
module text_term_ctrl
  import term_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [7:0]       key_ascii,
  output logic             key_ready,
  input  logic             clear_req,
  text_term_ctrl_if.master bus,
  output logic [6:0]       cur_col,
  output logic [4:0]       cur_row,
  output logic [4:0]       line_offset,
  output logic             busy
);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [6:0] COL_END  = 7'(COLS);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [4:0] BUF_LAST = 5'(BUF_ROWS - 1);

  state_t            state, state_n;
  logic [6:0]        col_n, clr_col, clr_col_n, le_val, prev_end;
  logic [4:0]        row_n, off_n, clr_row, clr_row_n, le_idx, prow_cur, prow_prev;
  logic [7:0]        ch_q, ch_n, wr_data;
  logic [6:0]        line_end [BUF_ROWS];
  logic              le_we, le_clr_all, wr_req, wr_done, wr_wait;
  logic [ADDR_W-1:0] wr_addr;

  assign prow_cur  = cur_row + line_offset;
  assign prow_prev = cur_row - 5'd1 + line_offset;
  assign prev_end  = line_end[prow_prev];
  assign key_ready = (state == ST_IDLE) & ~wr_wait & ~rst;
  assign busy      = (state != ST_IDLE);

  buf_port_mux #(.ADDR_W(ADDR_W)) u_mux (
    .clk  (clk_50m),
    .rst  (rst),
    .req  (wr_req),
    .addr (wr_addr),
    .data (wr_data),
    .done (wr_done),
    .bus  (bus)
  );

  // Outstanding-write flag tracks the mux's pending write through req/done
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)          wr_wait <= 1'b0;
    else if (wr_req)  wr_wait <= 1'b1;
    else if (wr_done) wr_wait <= 1'b0;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    col_n      = cur_col;
    row_n      = cur_row;
    off_n      = line_offset;
    ch_n       = ch_q;
    clr_row_n  = clr_row;
    clr_col_n  = clr_col;
    wr_req     = 1'b0;
    wr_addr    = ADDR_W'(cell_addr(prow_cur, cur_col));
    wr_data    = ch_q;
    le_we      = 1'b0;
    le_idx     = prow_cur;
    le_val     = '0;
    le_clr_all = 1'b0;
    if (!wr_wait) begin
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state_n   = ST_CLR_ALL;
            clr_row_n = '0;
            clr_col_n = '0;
          end else if (key_valid) begin
            ch_n = key_ascii;
            if (key_ascii >= 8'h20 && key_ascii <= 8'h7E)    state_n = ST_PUT;
            else if (key_ascii == CH_CR || key_ascii == CH_LF) state_n = ST_NEWLINE;
            else if (key_ascii == CH_BS)                     state_n = ST_BACKSPACE;
          end
        end
        ST_PUT: begin
          wr_req = 1'b1;
          if (cur_col == COL_LAST) begin
            // Parking the column at COLS makes NEWLINE record the full line end
            col_n   = COL_END;
            le_we   = 1'b1;
            le_val  = COL_END;
            state_n = ST_NEWLINE;
          end else begin
            col_n   = cur_col + 7'd1;
            state_n = ST_IDLE;
          end
        end
        ST_NEWLINE: begin
          le_we  = 1'b1;
          le_val = cur_col;
          col_n  = '0;
          if (cur_row != ROW_LAST) begin
            row_n   = cur_row + 5'd1;
            state_n = ST_IDLE;
          end else begin
            off_n     = line_offset + 5'd1;
            clr_col_n = '0;
            state_n   = ST_SCROLL_CLR;
          end
        end
        ST_SCROLL_CLR: begin
          wr_req  = 1'b1;
          wr_addr = ADDR_W'(cell_addr(prow_cur, clr_col));
          wr_data = BLANK_CH;
          if (clr_col == COL_LAST) begin
            le_we   = 1'b1;
            state_n = ST_IDLE;
          end else begin
            clr_col_n = clr_col + 7'd1;
          end
        end
        ST_BACKSPACE: begin
          state_n = ST_IDLE;
          if (cur_col != '0) begin
            col_n   = cur_col - 7'd1;
            wr_req  = 1'b1;
            wr_addr = ADDR_W'(cell_addr(prow_cur, cur_col - 7'd1));
            wr_data = BLANK_CH;
          end else if (cur_row != '0) begin
            row_n = cur_row - 5'd1;
            col_n = (prev_end > COL_LAST) ? COL_LAST : prev_end;
          end
        end
        ST_CLR_ALL: begin
          wr_req  = 1'b1;
          wr_addr = ADDR_W'(cell_addr(clr_row, clr_col));
          wr_data = BLANK_CH;
          if (clr_col == COL_LAST) begin
            clr_col_n = '0;
            if (clr_row == BUF_LAST) begin
              col_n      = '0;
              row_n      = '0;
              off_n      = '0;
              le_clr_all = 1'b1;
              state_n    = ST_IDLE;
            end else begin
              clr_row_n = clr_row + 5'd1;
            end
          end else begin
            clr_col_n = clr_col + 7'd1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      cur_col     <= '0;
      cur_row     <= '0;
      line_offset <= '0;
      ch_q        <= '0;
      clr_row     <= '0;
      clr_col     <= '0;
      for (int unsigned i = 0; i < BUF_ROWS; i++) line_end[5'(i)] <= '0;
    end else begin
      cur_col     <= col_n;
      cur_row     <= row_n;
      line_offset <= off_n;
      ch_q        <= ch_n;
      clr_row     <= clr_row_n;
      clr_col     <= clr_col_n;
      if (le_clr_all) begin
        for (int unsigned i = 0; i < BUF_ROWS; i++) line_end[5'(i)] <= '0;
      end else if (le_we) begin
        line_end[le_idx] <= le_val;
      end
    end
  end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Directed self-checking bench for text_term_ctrl with hand-computed expectations.
module tb_text_term_ctrl;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       key_ready;
  logic       clear_req;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic [4:0] line_offset;
  logic       busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [14:0] wq_addr[$];
  logic [7:0]  wq_din[$];

  text_term_ctrl_if #(.ADDR_W(15)) bus ();

  text_term_ctrl #(.ADDR_W(15)) dut (
    .clk_50m     (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_ascii   (key_ascii),
    .key_ready   (key_ready),
    .clear_req   (clear_req),
    .bus         (bus),
    .cur_col     (cur_col),
    .cur_row     (cur_row),
    .line_offset (line_offset),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (bus.buf_we) begin
      wq_addr.push_back(bus.buf_addr);
      wq_din.push_back(bus.buf_din);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int unsigned n = 1);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input int unsigned limit);
    int unsigned n = 0;
    while (key_ready !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    chk(tag, key_ready, 1);
  endtask

  task automatic send_key(input logic [7:0] ch);
    wait_ready("key_ready_wait", 200);
    key_valid = 1'b1;
    key_ascii = ch;
    step();
    key_valid = 1'b0;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_din.delete();
  endtask

  initial begin
    int unsigned bad;
    int unsigned n;

    rst          = 1'b1;
    key_valid    = 1'b0;
    key_ascii    = 8'h00;
    clear_req    = 1'b0;
    bus.wr_slot  = 1'b0;
    bus.disp_addr = 15'h1234;
    step(3);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_buf_we", bus.buf_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cursor", {cur_row, cur_col}, 0);
    chk("rst_offset", line_offset, 0);
    chk("rst_addr_passthru", bus.buf_addr, 15'h1234);
    rst = 1'b0;
    step();
    chk("post_rst_ready", key_ready, 1);

    // 'A' with write slots open
    bus.wr_slot = 1'b1;
    key_valid   = 1'b1;
    key_ascii   = 8'h41;
    step();
    key_valid = 1'b0;
    chk("A_busy_put", busy, 1);
    chk("A_ready_low", key_ready, 0);
    step();
    chk("A_we", bus.buf_we, 1);
    chk("A_addr", bus.buf_addr, 15'h000);
    chk("A_din", bus.buf_din, 8'h41);
    chk("A_col", cur_col, 1);
    step();
    chk("A_ready_back", key_ready, 1);
    chk("A_we_drop", bus.buf_we, 0);

    // 'B' with slots held off for 100 cycles; a clear_req mid-PUT is dropped
    clear_log();
    bus.wr_slot = 1'b0;
    key_valid   = 1'b1;
    key_ascii   = 8'h42;
    step();
    key_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      bus.disp_addr = 15'(i * 291 + 5);
      clear_req     = (i == 1);
      #1;
      if (bus.buf_we !== 1'b0 || bus.buf_addr !== bus.disp_addr) bad++;
      step();
    end
    clear_req = 1'b0;
    chk("B_hold_no_we", bad, 0);
    chk("B_hold_log", wq_addr.size(), 0);
    bus.wr_slot = 1'b1;
    #1;
    chk("B_we", bus.buf_we, 1);
    chk("B_addr", bus.buf_addr, 15'h001);
    chk("B_din", bus.buf_din, 8'h42);
    step();
    chk("B_one_write", wq_addr.size(), 1);
    step();
    chk("B_clear_dropped", busy, 0);
    chk("B_col", cur_col, 2);

    // Fill row 0 to wrap, then backspace across the wrap
    clear_log();
    for (int i = 0; i < 68; i++) send_key(8'h61 + 8'(i % 26));
    wait_ready("wrap_ready", 200);
    chk("wrap_col", cur_col, 0);
    chk("wrap_row", cur_row, 1);
    chk("wrap_writes", wq_addr.size(), 68);
    chk("wrap_last_addr", wq_addr[wq_addr.size()-1], 15'h045);
    chk("wrap_last_din", wq_din[wq_din.size()-1], 8'h70);
    clear_log();
    send_key(8'h08);
    wait_ready("bs_wrap_ready", 200);
    chk("bs_wrap_row", cur_row, 0);
    chk("bs_wrap_col", cur_col, 69);
    chk("bs_wrap_no_write", wq_addr.size(), 0);

    // Walk down to row 29, column 5
    for (int i = 0; i < 29; i++) send_key(8'h0D);
    wait_ready("cr_ready", 200);
    chk("row29", cur_row, 29);
    chk("row29_col", cur_col, 0);
    chk("row29_offset", line_offset, 0);
    for (int i = 0; i < 5; i++) send_key(8'h30 + 8'(i));
    wait_ready("row29_put_ready", 200);
    chk("row29_col5", cur_col, 5);
    chk("row29_last_addr", wq_addr[wq_addr.size()-1], 15'hE84);

    // Enter on the bottom line scrolls and blanks physical row 30
    clear_log();
    send_key(8'h0D);
    wait_ready("scroll_ready", 1000);
    chk("scroll_offset", line_offset, 1);
    chk("scroll_row", cur_row, 29);
    chk("scroll_col", cur_col, 0);
    chk("scroll_writes", wq_addr.size(), 70);
    bad = 0;
    for (int i = 0; i < 70 && i < int'(wq_addr.size()); i++)
      if (wq_addr[i] !== 15'(32'hF00 + i) || wq_din[i] !== 8'h20) bad++;
    chk("scroll_cells", bad, 0);

    // Unsupported code is consumed with no effect
    clear_log();
    send_key(8'h01);
    wait_ready("ign_ready", 200);
    chk("ign_cursor", {cur_row, cur_col}, {5'd29, 7'd0});
    chk("ign_no_write", wq_addr.size(), 0);

    // Char then backspace on the scrolled bottom line
    clear_log();
    send_key(8'h78);
    send_key(8'h08);
    wait_ready("bs_ready", 200);
    chk("bs_col", cur_col, 0);
    chk("bs_writes", wq_addr.size(), 2);
    chk("bs_put_addr", wq_addr[0], 15'hF00);
    chk("bs_put_din", wq_din[0], 8'h78);
    chk("bs_blank_addr", wq_addr[1], 15'hF00);
    chk("bs_blank_din", wq_din[1], 8'h20);

    // Full clear beats a simultaneous key
    send_key(8'h61);
    send_key(8'h62);
    send_key(8'h63);
    wait_ready("clr_pre_ready", 200);
    chk("clr_pre_col", cur_col, 3);
    clear_log();
    clear_req = 1'b1;
    key_valid = 1'b1;
    key_ascii = 8'h7A;
    step();
    clear_req = 1'b0;
    key_valid = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_key_not_taken", cur_col, 3);
    wait_ready("clr_done_ready", 10000);
    chk("clr_writes", wq_addr.size(), 2240);
    bad = 0;
    for (int i = 0; i < 2240 && i < int'(wq_addr.size()); i++)
      if (wq_addr[i] !== 15'((i / 70) * 128 + (i % 70)) || wq_din[i] !== 8'h20) bad++;
    chk("clr_cells", bad, 0);
    chk("clr_cursor", {cur_row, cur_col}, 0);
    chk("clr_offset", line_offset, 0);
    chk("clr_idle", busy, 0);

    // Backspace at the home position does nothing
    clear_log();
    send_key(8'h08);
    wait_ready("home_bs_ready", 200);
    chk("home_bs_cursor", {cur_row, cur_col}, 0);
    chk("home_bs_no_write", wq_addr.size(), 0);

    // Reset in the middle of a full clear
    send_key(8'h71);
    wait_ready("q_ready", 200);
    clear_log();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step(60);
    n = 0;
    while (bus.buf_we !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("mid_clr_we", bus.buf_we, 1);
    chk("mid_clr_col", cur_col, 1);
    chk("mid_clr_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_we", bus.buf_we, 0);
    chk("abort_ready", key_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cursor", {cur_row, cur_col}, 0);
    chk("abort_offset", line_offset, 0);
    n = wq_addr.size();
    step(3);
    rst = 1'b0;
    step(5);
    chk("abort_no_more_writes", wq_addr.size(), n);
    chk("abort_ready_after", key_ready, 1);
    chk("abort_idle_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_term_ctrl.md
Name: text_term_ctrl

Overview:
- Terminal write controller for the 70x30 character display.
- Accepts ASCII codes from the keyboard path and sequences all writes into the shared single-port char buffer.
- Tracks the cursor, per-line end columns and the scroll offset, and performs backspace, newline, scroll-clear and full-screen clear.
- Shares the buffer port with the display read path by stealing only blanking cycles. The display path reads at all other times.

Parameters:
- COLS, 70: characters per line.
- ROWS, 30: visible lines.
- BUF_ROWS, 32: physical rows in the buffer (power of two; scroll wraps modulo this).
- ADDR_W, 15: buffer address width.
- BLANK_CH, 8'h20: fill code for erased cells.

Ports:
- clk_50m, in, 1: system clock, same clock as the char buffer.
- rst, in, 1: asynchronous, active-high reset.
- key_valid, in, 1: ASCII code available.
- key_ascii, in, 8: ASCII code.
- key_ready, out, 1: controller can accept a code.
- clear_req, in, 1: one-cycle pulse; erase the whole screen.
- wr_slot, in, 1: high while the display is blanking (~valid); a buffer write is permitted this cycle.
- disp_addr, in, ADDR_W: display read address.
- buf_addr, out, ADDR_W: address to the char buffer.
- buf_din, out, 8: write data.
- buf_we, out, 1: write enable.
- cur_col, out, 7: cursor column.
- cur_row, out, 5: cursor visible row.
- line_offset, out, 5: physical row shown at visible row 0.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset values: cur_col=0, cur_row=0, line_offset=0, key_ready=0 during reset, busy=0, wr_pending=0, buf_we=0. All line_end entries=0. State=IDLE.
- Physical row: prow = (vrow + line_offset) mod BUF_ROWS.
- Write address: {zeros, prow[4:0], col[6:0]}, zero-extended to ADDR_W.
- Port sharing:
  - buf_we = wr_pending & wr_slot (combinational).
  - buf_addr = buf_we ? wr_addr : disp_addr (combinational).
  - buf_din = wr_data.
  - wr_pending clears on the cycle buf_we=1. The FSM waits in its current state while wr_pending=1.
  - The display is never disturbed outside wr_slot.
- Handshake:
  - key_ready=1 only in IDLE with wr_pending=0.
  - A code is accepted when key_valid & key_ready. Exactly one code per accepted cycle.
- clear_req:
  - Sampled in IDLE only, and wins over a simultaneous key_valid; that key is not accepted.
  - A clear_req pulse in any other state is dropped.
- FSM states and transitions:
  - IDLE: dispatches on the accepted code, or on clear_req.
  - PUT:
    - Entered for codes 0x20-0x7E.
    - Queues a write of the code at (cur_row, cur_col), then col+1.
    - If col becomes COLS, performs a wrap: line_end[row]=COLS, then NEWLINE.
    - Otherwise returns to IDLE.
  - NEWLINE:
    - Entered for 0x0D or 0x0A.
    - On Enter: line_end[row]=cur_col. On wrap: line_end[row]=COLS as set in PUT. The two cases are distinguished by this write.
    - Sets col=0.
    - If row<ROWS-1: row+1, then IDLE.
    - Otherwise: line_offset+1 (mod BUF_ROWS), row stays ROWS-1, then SCROLL_CLR.
  - SCROLL_CLR:
    - Writes BLANK_CH to columns 0..COLS-1 of the new bottom physical row, one write per granted slot.
    - Sets line_end of that row to 0, then IDLE.
  - BACKSPACE:
    - Entered for 0x08.
    - If col>0: col-1, queue BLANK_CH at the new col, then IDLE.
    - If col=0 and row>0: row-1, col=min(line_end[row-1], COLS-1), no write, then IDLE.
    - If col=0 and row=0: no-op, return to IDLE.
  - CLR_ALL:
    - Writes BLANK_CH to every cell of all BUF_ROWS x COLS cells: 2240 writes, row-major from physical 0.
    - Then cur_col=0, cur_row=0, line_offset=0, all line_end=0, then IDLE.
- Any other code: ignored; stays in IDLE and the code is consumed.
- rst asserted mid-sweep aborts the sweep immediately; buf_we drops in the same cycle (async). Partially written cells stay as written.
- Column counter never exceeds COLS-1 when visible in IDLE.

Decomposition:
- Package term_pkg:
  - Parameters COLS, ROWS, BUF_ROWS, BLANK_CH.
  - ASCII constants CH_BS=8'h08, CH_LF=8'h0A, CH_CR=8'h0D.
  - FSM state enum.
- Sub-module buf_port_mux: wr_pending register plus the buf_we/buf_addr/buf_din mux. Interface: req, addr, data in; done pulse out.

Test Plan:
- Reset, then send 'A' (0x41) with wr_slot=1 → one buf_we pulse, buf_addr=0x000, buf_din=0x41. cur_col=1, key_ready returns high.
- Hold wr_slot=0 for 100 cycles while sending 'B' → buf_addr tracks disp_addr, no buf_we. The first cycle wr_slot=1 writes 0x42 at 0x001.
- 70 printable keys on row 0 → cur_col=0, cur_row=1, line_end[0]=70. Then backspace → cur_row=0, cur_col=69, no write.
- Cursor at row 29 col 5, send 0x0D → line_offset=1, cur_row=29. 70 writes of 0x20 to physical row 30 (addr 0xF00..0xF45).
- Type 3 chars, send clear_req with key_valid in the same cycle → key not accepted, busy=1, 2240 writes of 0x20. Afterwards cursor=(0,0), line_offset=0.
- Assert rst mid-CLR_ALL → buf_we=0 immediately, all outputs at reset values, key_ready=1 after rst release.
